// File: rtl/addsub_pkg.sv
// Shared types and helpers for the round-robin add/sub scheduler.
package addsub_pkg;

    localparam int DATA_W   = 32;
    localparam int MAX_NREQ = 16;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              sub;
    } op_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addsub_rr_sched_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping.
module rr_arbiter
    import addsub_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_any
);

    logic            found_s;
    logic [ID_W-1:0] idx_s;

    // Rotating priority search starting at ptr
    always_comb begin
        int cand;
        found_s = 1'b0;
        idx_s   = '0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found_s && req[cand]) begin
                found_s = 1'b1;
                idx_s   = ID_W'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant, suppressed when the pipe cannot take a new op
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = en & found_s & (idx_s == ID_W'(i));
        end
    end

    assign gnt_idx = idx_s;
    assign gnt_any = en & found_s;

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one external 32-bit adder between NREQ requesters.
// Optional ADDSUB_RR_OVF_EN adds a registered signed-overflow flag (rsp_ovf).
module addsub_rr_sched
    import addsub_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = clog2_min1(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    input  logic [NREQ-1:0]        req_sub,
    output logic [DATA_W-1:0]      add_x,
    output logic [DATA_W-1:0]      add_y,
    output logic                   add_sub,
    input  logic [DATA_W-1:0]      add_s,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id
`ifdef ADDSUB_RR_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);

    op_t               op_q, op_d;
    logic              op_valid_q, op_valid_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              ovf_q, ovf_d, ovf_s;

    logic              adv_rsp_s, adv_op_s;
    logic [NREQ-1:0]   gnt_s;
    logic [ID_W-1:0]   gnt_idx_s;
    logic              gnt_any_s;

    assign adv_rsp_s = ~rsp_valid_q | rsp_ready;
    assign adv_op_s  = ~op_valid_q | adv_rsp_s;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (adv_op_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    assign req_ready = gnt_s;

`ifdef ADDSUB_RR_OVF_EN
    // Signed overflow: operands effectively share a sign that the sum does not
    assign ovf_s = (op_q.x[DATA_W-1] == (op_q.y[DATA_W-1] ^ op_q.sub)) &
                   (add_s[DATA_W-1] != op_q.x[DATA_W-1]);
    assign rsp_ovf = ovf_q;
`else
    assign ovf_s = 1'b0;
`endif

    // Next-state for the OP stage and the round-robin pointer
    always_comb begin
        op_d       = op_q;
        op_valid_d = op_valid_q;
        op_id_d    = op_id_q;
        ptr_d      = ptr_q;
        if (gnt_any_s) begin
            op_d.x     = req_x[DATA_W*int'(gnt_idx_s) +: DATA_W];
            op_d.y     = req_y[DATA_W*int'(gnt_idx_s) +: DATA_W];
            op_d.sub   = req_sub[gnt_idx_s];
            op_id_d    = gnt_idx_s;
            op_valid_d = 1'b1;
            ptr_d      = ID_W'((int'(gnt_idx_s) + 1) % NREQ);
        end else if (adv_rsp_s) begin
            op_valid_d = 1'b0;
        end else begin
            op_valid_d = op_valid_q;
        end
    end

    // Next-state for the RSP stage; holds everything while stalled
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ovf_d       = ovf_q;
        if (adv_rsp_s) begin
            rsp_valid_d = op_valid_q;
            if (op_valid_q) begin
                rsp_data_d = add_s;
                rsp_id_d   = op_id_q;
                ovf_d      = ovf_s;
            end else begin
                rsp_data_d = rsp_data_q;
            end
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Pipeline registers; reset drops any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            op_id_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            op_q        <= op_d;
            op_valid_q  <= op_valid_d;
            op_id_q     <= op_id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ovf_q       <= ovf_d;
        end
    end

    assign add_x     = op_q.x;
    assign add_y     = op_q.y;
    assign add_sub   = op_q.sub;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Directed self-checking bench for addsub_rr_sched with a behavioural adder model.
module tb_addsub_rr_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, req_sub;
    logic [127:0] req_x, req_y;
    logic [31:0]  add_x, add_y, add_s, rsp_data;
    logic         add_sub, rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
`ifdef ADDSUB_RR_OVF_EN
    logic         rsp_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign add_s = add_sub ? (add_x - add_y) : (add_x + add_y);

    addsub_rr_sched #(.NREQ(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_sub(req_sub),
        .add_x(add_x), .add_y(add_y), .add_sub(add_sub), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ADDSUB_RR_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic sub);
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_sub[i]        = sub;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated op: waits for grant, then for the response; lat counts posedges from the accept edge
    task automatic do_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic sub,
                         output logic [31:0] d, output logic [1:0] id, output logic ovf,
                         output int lat, output bit ok);
        ok = 1'b0; lat = 0; d = '0; id = '0; ovf = 1'b0;
        set_op(i, x, y, sub);
        req_valid[i] = 1'b1;
        #1;
        for (int w = 0; w < 10 && !req_ready[i]; w++) begin
            @(negedge clk); #1;
        end
        if (req_ready[i]) begin
            @(negedge clk);
            req_valid[i] = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                #1;
                if (rsp_valid) begin
                    ok = 1'b1; lat = c; d = rsp_data; id = rsp_id;
`ifdef ADDSUB_RR_OVF_EN
                    ovf = rsp_ovf;
`endif
                    break;
                end
                @(negedge clk);
            end
        end
        req_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b1;
        req_x = '0; req_y = '0; req_sub = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== 35'd0) begin
            n_fail++; $display("FAIL reset_rsp: got %b/%h/%h want 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        n_checks++;
        if ({add_x, add_y, add_sub} !== 65'd0) begin
            n_fail++; $display("FAIL reset_add: got %h/%h/%b want 0/0/0", add_x, add_y, add_sub);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [31:0] d; logic [1:0] id; logic ovf; int lat; bit ok;
        do_op(0, 32'd5, 32'd3, 1'b0, d, id, ovf, lat, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL single_rsp: got no response want one"); end
        n_checks++;
        if ({id, d} !== {2'd0, 32'd8}) begin n_fail++; $display("FAIL single_data: got id %0d data %h want id 0 data 8", id, d); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] id; logic ovf; int lat; bit ok;
        do_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, d, id, ovf, lat, ok);
        n_checks++;
        if ({ok, id, d} !== {1'b1, 2'd1, 32'h0}) begin n_fail++; $display("FAIL wrap_add: got ok %b id %0d data %h want 1/1/00000000", ok, id, d); end
`ifdef ADDSUB_RR_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_add_ovf: got %b want 0", ovf); end
`endif
        do_op(1, 32'h0, 32'h1, 1'b1, d, id, ovf, lat, ok);
        n_checks++;
        if ({ok, id, d} !== {1'b1, 2'd1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL wrap_sub: got ok %b id %0d data %h want 1/1/ffffffff", ok, id, d); end
`ifdef ADDSUB_RR_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_sub_ovf: got %b want 0", ovf); end
`endif
    endtask

    task automatic test_fairness();
        int acc[$]; int rid[$]; logic [31:0] rdat[$];
        int w; logic [31:0] exp_d;
        apply_reset();
        for (int i = 0; i < 4; i++) set_op(i, 32'h1000 * (i + 1), 32'(i + 1), 1'b0);
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 8) begin
                w = -1;
                for (int b = 3; b >= 0; b--) if (req_ready[b]) w = b;
                if ($countones(req_ready) != 1) w = -1;
                acc.push_back(w);
            end
            if (rsp_valid) begin
                rid.push_back(int'(rsp_id));
                rdat.push_back(rsp_data);
            end
            @(negedge clk);
            if (c == 7) req_valid = 4'b0000;
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (acc[k] !== k % 4) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, acc[k], k % 4); end
        end
        n_checks++;
        if (rid.size() !== 8) begin
            n_fail++; $display("FAIL fair_rsp_count: got %0d want 8", rid.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_d = 32'h1000 * ((k % 4) + 1) + 32'((k % 4) + 1);
                n_checks++;
                if (rid[k] !== k % 4 || rdat[k] !== exp_d) begin
                    n_fail++; $display("FAIL fair_rsp[%0d]: got id %0d data %h want id %0d data %h", k, rid[k], rdat[k], k % 4, exp_d);
                end
            end
        end
    endtask

    task automatic test_stall();
        set_op(0, 32'd100, 32'd1, 1'b0);
        set_op(2, 32'd10, 32'd4, 1'b1);
        set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        req_valid = 4'b0101; rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_grant0: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_grant2: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++;
            if ({req_ready, rsp_valid, rsp_id, rsp_data, add_x} !== {4'b0000, 1'b1, 2'd0, 32'd101, 32'd10}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got rdy %b v %b id %0d data %h addx %h want 0000/1/0/65/a",
                                   s, req_ready, rsp_valid, rsp_id, rsp_data, add_x);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data} !== {4'b0010, 1'b1, 2'd0, 32'd101}) begin
            n_fail++; $display("FAIL stall_release: got rdy %b v %b id %0d data %h want 0010/1/0/65", req_ready, rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 32'd6}) begin
            n_fail++; $display("FAIL stall_second: got v %b id %0d data %h want 1/2/6", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 32'h2345_6789}) begin
            n_fail++; $display("FAIL stall_third: got v %b id %0d data %h want 1/1/23456789", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk); @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL rstmid_full: got v %b rdy %b want 1/0000", rsp_valid, req_ready);
        end
        rst_n = 1'b0;
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, add_x, add_y, add_sub} !== 100'd0) begin
            n_fail++; $display("FAIL rstmid_clear: got v %b id %0d data %h addx %h addy %h sub %b want all 0",
                               rsp_valid, rsp_id, rsp_data, add_x, add_y, add_sub);
        end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1; if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_emit: got response after reset want none"); end
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ovf();
        logic [31:0] d; logic [1:0] id; logic ovf; int lat; bit ok;
        do_op(3, 32'h7FFF_FFFF, 32'h1, 1'b0, d, id, ovf, lat, ok);
        n_checks++;
        if ({ok, id, d} !== {1'b1, 2'd3, 32'h8000_0000}) begin n_fail++; $display("FAIL ovf_add: got ok %b id %0d data %h want 1/3/80000000", ok, id, d); end
`ifdef ADDSUB_RR_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_add_flag: got %b want 1", ovf); end
`endif
        do_op(3, 32'h8000_0000, 32'h1, 1'b1, d, id, ovf, lat, ok);
        n_checks++;
        if ({ok, id, d} !== {1'b1, 2'd3, 32'h7FFF_FFFF}) begin n_fail++; $display("FAIL ovf_sub: got ok %b id %0d data %h want 1/3/7fffffff", ok, id, d); end
`ifdef ADDSUB_RR_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_flag: got %b want 1", ovf); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_stall();
        test_reset_mid_op();
        test_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
